uart_num_parser: RTL

Byte-stream parser directly downstream of the UART receiver. Consumes one received byte per `rx_done` pulse and converts ASCII signed decimal integers into two's-complement values for the matrix-entry logic. Separators are space, comma, CR and LF. Each accepted number carries its position within the current line, so the matrix loader can infer row/column layout.

---
 rtl/uart_num_parser.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_num_parser.sv
// -----------------------------------------------------------------------------
// uart_num_parser
//
// Converts a stream of ASCII bytes from the UART receiver into signed
// two's-complement integers. Each number is tagged with its 0-based position
// within the current line, so the matrix loader can infer the row and column.
//
// Byte classes:
//   digit     0x30..0x39
//   minus     0x2D
//   delimiter space, comma, CR, LF
//   Anything else is illegal.
//
// Handshake: there is no valid/ready pair. Each rx_done pulse delivers exactly
// one byte, and the parser accepts it in that cycle. Every output strobe
// (num_valid, line_end, err) is high for exactly one cycle, in the cycle after
// the byte that caused it. The consumer has no backpressure and must sample a
// strobe in its cycle. num_data, num_idx and err_code hold their values until
// the next strobe that updates them.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx_data    received byte, meaningful only while rx_done = 1
//   rx_done    single-cycle byte strobe
//   num_data   parsed signed value (VAL_W bits)
//   num_valid  single-cycle strobe: num_data/num_idx are new
//   num_idx    position of the number within the current line (IDX_W bits)
//   line_end   single-cycle strobe on LF
//   err        single-cycle error strobe
//   err_code   1 = illegal char, 2 = overflow, 3 = lone '-'
//   dbg_state  current parser state (0 IDLE, 1 SIGN, 2 DIGIT, 3 SKIP)
// -----------------------------------------------------------------------------
module uart_num_parser #(
  parameter int VAL_W = 16,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic [VAL_W-1:0] num_data,
  output logic             num_valid,
  output logic [IDX_W-1:0] num_idx,
  output logic             line_end,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SIGN  = 2'd1,
    S_DIGIT = 2'd2,
    S_SKIP  = 2'd3
  } state_t;

  // The four spare bits hold acc*10+9 for any acc up to the positive limit.
  // Because of that headroom, the overflow test sees the true value and not a
  // wrapped one.
  localparam int ACC_W = VAL_W + 4;
  localparam logic [ACC_W-1:0] ACC_MAX = {5'b00000, {(VAL_W-1){1'b1}}};

  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_LONE_MINUS = 2'd3;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             neg;
  logic [IDX_W-1:0] idx;

  // Byte classification
  logic is_digit;
  logic is_minus;
  logic is_lf;
  logic is_delim;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_minus = (rx_data == 8'h2D);
  assign is_lf    = (rx_data == 8'h0A);
  assign is_delim = (rx_data == 8'h20) || (rx_data == 8'h2C) ||
                    (rx_data == 8'h0D) || is_lf;

  // Datapath
  logic [ACC_W-1:0] dig;
  logic [ACC_W-1:0] nxt;
  logic [VAL_W-1:0] mag;
  logic [VAL_W-1:0] signed_val;
  logic [IDX_W-1:0] idx_inc;

  assign dig        = {{(ACC_W-4){1'b0}}, rx_data[3:0]};
  assign nxt        = (acc << 3) + (acc << 1) + dig;
  assign mag        = acc[VAL_W-1:0];
  assign signed_val = neg ? ({VAL_W{1'b0}} - mag) : mag;
  // The index saturates at all-ones until the next LF clears it.
  assign idx_inc    = (idx == {IDX_W{1'b1}}) ? idx : idx + IDX_W'(1);

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      neg       <= 1'b0;
      idx       <= '0;
      num_data  <= '0;
      num_valid <= 1'b0;
      num_idx   <= '0;
      line_end  <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      num_valid <= 1'b0;
      line_end  <= 1'b0;
      err       <= 1'b0;

      if (rx_done) begin
        case (state)
          S_IDLE: begin
            if (is_digit) begin
              acc   <= dig;
              neg   <= 1'b0;
              state <= S_DIGIT;
            end else if (is_minus) begin
              acc   <= '0;
              neg   <= 1'b1;
              state <= S_SIGN;
            end else if (!is_delim) begin
              err      <= 1'b1;
              err_code <= ERR_ILLEGAL;
              state    <= S_SKIP;
            end
          end

          S_SIGN: begin
            if (is_digit) begin
              acc   <= dig;
              state <= S_DIGIT;
            end else if (is_delim) begin
              err      <= 1'b1;
              err_code <= ERR_LONE_MINUS;
              state    <= S_IDLE;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_ILLEGAL;
              state    <= S_SKIP;
            end
          end

          S_DIGIT: begin
            if (is_digit) begin
              if (nxt > ACC_MAX) begin
                err      <= 1'b1;
                err_code <= ERR_OVERFLOW;
                state    <= S_SKIP;
              end else begin
                acc <= nxt;
              end
            end else if (is_delim) begin
              num_data  <= signed_val;
              num_idx   <= idx;
              num_valid <= 1'b1;
              idx       <= idx_inc;
              state     <= S_IDLE;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_ILLEGAL;
              state    <= S_SKIP;
            end
          end

          S_SKIP: begin
            if (is_delim) begin
              state <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase

        // LF ends the line in every state. It is placed after the case so that
        // it overrides any index increment from a number closed by this LF. That
        // number has already captured its index in num_idx.
        if (is_lf) begin
          line_end <= 1'b1;
          idx      <= '0;
        end
      end
    end
  end

endmodule
